// File: rtl/mux_scan_ctrl.sv
// Purpose: sequences sel 0..3 into a 4:1 selector, samples mux_y after SETTLE, packs a 4-bit frame.
// Latency: en seen at edge k -> frame_valid at edge k+1+4*DWELL; frames back-to-back every 4*DWELL cycles.
// Backpressure: frame held while valid & !ready; a frame completing into a held slot is dropped and sets overrun.
//
// Ports:
//   clk, rst (async active-low)       : clock and reset
//   en, mode                          : scan enable (level), 0=auto / 1=manual (latched when leaving IDLE)
//   step_btn                          : raw push-button, synchronized and debounced internally
//   mux_y / sel                       : selector return value / select driven to the selector
//   frame, frame_valid, frame_ready   : output frame with valid/ready handshake
//   busy, overrun, clr_ovr            : not-IDLE flag, sticky drop flag and its synchronous clear
module mux_scan_ctrl #(
  parameter int DWELL     = 4,
  parameter int SETTLE    = 1,
  parameter int DB_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       step_btn,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic       overrun,
  input  logic       clr_ovr
);

  localparam int CW  = $clog2(DWELL);
  localparam int DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_STEP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [3:0]     part;
  logic [3:0]     part_nxt;
  logic           mode_l;
  logic           en_q;
  logic           dwell_end;
  logic           frame_done;

  logic           btn_s1, btn_s2;
  logic           db_lvl;
  logic [DBW-1:0] db_cnt;
  logic           step_p;

  // Partial frame including this edge's sample, so a sample that lands on
  // the final dwell edge of channel 3 (SETTLE == DWELL-1) still reaches frame.
  always_comb begin
    part_nxt = part;
    if (state == SCAN && cnt == CW'(SETTLE))
      part_nxt[sel] = mux_y;
  end

  assign dwell_end  = (state == SCAN) && (cnt == CW'(DWELL - 1));
  assign frame_done = dwell_end && (sel == 2'd3);

  // Synchronizer plus debouncer; step_p is a one-cycle pulse on a debounced rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      db_lvl <= 1'b0;
      db_cnt <= '0;
      step_p <= 1'b0;
    end else begin
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
      step_p <= 1'b0;
      if (btn_s2 != db_lvl) begin
        if (db_cnt == DBW'(DB_CYCLES - 1)) begin
          db_lvl <= btn_s2;
          db_cnt <= '0;
          step_p <= btn_s2;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end else begin
        db_cnt <= '0;   // any bounce back restarts the count
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= '0;
      part        <= 4'd0;
      mode_l      <= 1'b0;
      en_q        <= 1'b0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // en is registered once; all decisions use en_q, which gives the
      // one-cycle gap between en being seen and the first scan edge.
      en_q <= en;

      // Output slot: a completion may load together with a same-edge consume.
      if (frame_done) begin
        if (!frame_valid || frame_ready) begin
          frame       <= part_nxt;
          frame_valid <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      // Set wins over clear.
      if (frame_done && frame_valid && !frame_ready)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          sel <= 2'd0;
          cnt <= '0;
          if (en_q && (!mode || step_p)) begin
            state  <= SCAN;
            busy   <= 1'b1;
            mode_l <= mode;
          end
        end
        SCAN: begin
          part <= part_nxt;
          if (dwell_end) begin
            cnt <= '0;
            if (sel != 2'd3) begin
              sel <= sel + 2'd1;
              if (mode_l)
                state <= WAIT_STEP;
            end else begin
              // en only matters at frame end; a started frame always finishes.
              sel <= 2'd0;
              if (!en_q) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else if (mode_l) begin
                state <= WAIT_STEP;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_STEP: begin
          cnt <= '0;
          if (!en_q) begin
            state <= IDLE;
            busy  <= 1'b0;
            sel   <= 2'd0;
            part  <= 4'd0;   // abandoned partial frame
          end else if (step_p) begin
            state <= SCAN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default parameters.
  logic       rst, en, mode, step_btn, mux_y, frame_ready, clr_ovr;
  logic [1:0] sel;
  logic [3:0] frame;
  logic       frame_valid, busy, overrun;
  logic [3:0] a;          // selector inputs seen by the main instance
  assign mux_y = a[sel];  // behavioural 4:1 selector

  mux_scan_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step_btn(step_btn),
    .mux_y(mux_y), .sel(sel), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  // Second instance: SETTLE=0, DWELL=2, fed a random mux_y every cycle.
  logic       en2, y2, btn2, ready2, clr2, mode2;
  logic [1:0] sel2;
  logic [3:0] frame2;
  logic       fv2, busy2, ovr2;

  mux_scan_ctrl #(.DWELL(2), .SETTLE(0), .DB_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .step_btn(btn2),
    .mux_y(y2), .sel(sel2), .frame(frame2), .frame_valid(fv2),
    .frame_ready(ready2), .busy(busy2), .overrun(ovr2), .clr_ovr(clr2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference for scan position: after scan-relative edge t (t=1 is the edge
  // where en is first seen), the channel is ((t-2)/DWELL) mod 4, 0 before that.
  function automatic logic [1:0] exp_sel(input int t, input int dw);
    if (t < 2) return 2'd0;
    return 2'((t - 2) / dw);
  endfunction

  logic ylog [0:63];
  logic [3:0] a1, a2, a3, a4, ef;

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; step_btn = 1'b0; frame_ready = 1'b0;
    clr_ovr = 1'b0; a = 4'd0;
    en2 = 1'b0; y2 = 1'b0; btn2 = 1'b0; ready2 = 1'b1; clr2 = 1'b0; mode2 = 1'b0;

    // ---------------- reset state ----------------
    #3;
    chk("rst_sel",     32'(sel), 0);
    chk("rst_frame",   32'(frame), 0);
    chk("rst_valid",   32'(frame_valid), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 0);

    // ---------------- auto scan, a=1010, ready=1, en dropped with sel=1 ----------------
    a = 4'b1010; frame_ready = 1'b1; mode = 1'b0; en = 1'b1;
    for (int t = 1; t <= 66; t++) begin
      tick();
      if (t == 54) en = 1'b0;   // channel 1 of the fourth frame
      chk($sformatf("auto_sel_t%0d", t), 32'(sel), 32'(exp_sel(t, 4)));
      chk($sformatf("auto_valid_t%0d", t), 32'(frame_valid),
          32'(t == 18 || t == 34 || t == 50 || t == 66));
      chk($sformatf("auto_busy_t%0d", t), 32'(busy), 32'(t >= 2 && t < 66));
      if (t == 18 || t == 34 || t == 50 || t == 66)
        chk($sformatf("auto_frame_t%0d", t), 32'(frame), 32'(a));
    end
    tick();
    chk("endrun_valid", 32'(frame_valid), 0);
    chk("endrun_busy",  32'(busy), 0);
    chk("endrun_sel",   32'(sel), 0);

    // ---------------- backpressure ----------------
    a1 = 4'($urandom_range(0, 15));
    a2 = a1 ^ 4'($urandom_range(1, 15));
    a3 = a1 ^ 4'($urandom_range(1, 15));
    a = a1; frame_ready = 1'b0; en = 1'b1;
    for (int t = 1; t <= 59; t++) begin
      tick();
      if (t == 18) begin
        chk("bp_first_valid", 32'(frame_valid), 1);
        chk("bp_first_frame", 32'(frame), 32'(a1));
        chk("bp_first_ovr",   32'(overrun), 0);
        a = a2;
      end
      if (t == 25) chk("bp_hold_frame", 32'(frame), 32'(a1));
      if (t == 33) chk("bp_pre_ovr",    32'(overrun), 0);
      if (t == 34) begin
        chk("bp_second_frame", 32'(frame), 32'(a1));
        chk("bp_second_valid", 32'(frame_valid), 1);
        chk("bp_second_ovr",   32'(overrun), 1);
        a = a3;
      end
      if (t == 49) frame_ready = 1'b1;   // coincides with the third completion
      if (t == 50) begin
        chk("bp_third_frame", 32'(frame), 32'(a3));
        chk("bp_third_valid", 32'(frame_valid), 1);
        chk("bp_third_ovr",   32'(overrun), 1);
        frame_ready = 1'b0;
        clr_ovr = 1'b1;
      end
      if (t == 51) begin
        chk("bp_clr_ovr", 32'(overrun), 0);
        clr_ovr = 1'b0;
      end
    end

    // ---------------- asynchronous reset mid-dwell ----------------
    chk("pre_rst_sel",   32'(sel), 2);
    chk("pre_rst_valid", 32'(frame_valid), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_sel",   32'(sel), 0);
    chk("async_frame", 32'(frame), 0);
    chk("async_valid", 32'(frame_valid), 0);
    chk("async_busy",  32'(busy), 0);
    chk("async_ovr",   32'(overrun), 0);
    #1 rst = 1'b1;
    a4 = 4'($urandom_range(0, 15));
    a = a4; frame_ready = 1'b1;
    for (int t = 1; t <= 18; t++) tick();
    chk("post_rst_valid", 32'(frame_valid), 1);
    chk("post_rst_frame", 32'(frame), 32'(a4));
    en = 1'b0;
    for (int t = 19; t <= 36; t++) tick();
    chk("post_rst_idle", 32'(busy), 0);

    // ---------------- manual stepping ----------------
    a = 4'b0110; mode = 1'b1; frame_ready = 1'b0; en = 1'b1;
    tick();
    tick();
    chk("man_wait_idle", 32'(busy), 0);   // no press yet
    for (int p = 1; p <= 4; p++) begin
      if (p == 2) begin
        for (int b = 0; b < 4; b++) begin
          step_btn = 1'b1;
          repeat (3) tick();
          step_btn = 1'b0;
          repeat (3) tick();
        end
        repeat (12) tick();
        chk("man_bounce_sel", 32'(sel), 1);
      end
      step_btn = 1'b1;
      repeat (20) tick();
      step_btn = 1'b0;
      repeat (20) tick();
      chk($sformatf("man_sel_p%0d", p), 32'(sel), 32'(p % 4));
      chk($sformatf("man_valid_p%0d", p), 32'(frame_valid), 32'(p == 4));
    end
    chk("man_frame", 32'(frame), 32'(4'b0110));
    chk("man_busy",  32'(busy), 1);
    frame_ready = 1'b1;
    tick();
    chk("man_consumed", 32'(frame_valid), 0);
    en = 1'b0;
    repeat (3) tick();
    chk("man_idle_busy", 32'(busy), 0);
    chk("man_idle_sel",  32'(sel), 0);

    // ---------------- SETTLE=0, DWELL=2, random mux_y ----------------
    en2 = 1'b1;
    y2 = 1'($urandom_range(0, 1));
    ylog[1] = y2;
    for (int t = 1; t <= 42; t++) begin
      tick();
      chk($sformatf("rnd_sel_t%0d", t), 32'(sel2), 32'(exp_sel(t, 2)));
      chk($sformatf("rnd_valid_t%0d", t), 32'(fv2), 32'(t >= 10 && (t - 10) % 8 == 0));
      if (t >= 10 && (t - 10) % 8 == 0) begin
        // channel i of frame j is sampled at edge 3 + 8j + 2i
        ef = {ylog[t - 1], ylog[t - 3], ylog[t - 5], ylog[t - 7]};
        chk($sformatf("rnd_frame_t%0d", t), 32'(frame2), 32'(ef));
      end
      y2 = 1'($urandom_range(0, 1));
      ylog[t + 1] = y2;
    end
    chk("rnd_ovr", 32'(ovr2), 0);
    en2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
